// File: rtl/user_uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of it.
// Frames go out LSB first; each bit lasts clk_div cycles, with 0 treated as 1.
module user_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [15:0]      clk_div,
  input  logic             tx_en,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             tx_o,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       shift_q, shift_d;
  logic [15:0]      div_q, div_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [15:0]      div_new;
  logic             push, pop, fifo_empty, baud_done;

  assign div_new    = (clk_div == 16'd0) ? 16'd1 : clk_div;
  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign baud_done  = (baud_q == 16'd0);
  assign fifo_count = count_q;

  // FIFO storage needs no reset; only pointers and count define its contents.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      shift_q <= '0;
      div_q   <= 16'd1;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      shift_q <= shift_d;
      div_q   <= div_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    shift_d = shift_q;
    div_d   = div_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    if (state_q != StIdle) begin
      baud_d = baud_done ? (div_q - 16'd1) : (baud_q - 16'd1);
    end
    case (state_q)
      StIdle: begin
        if (tx_en && !fifo_empty) begin
          pop     = 1'b1;
          state_d = StStart;
          shift_d = mem_q[rd_ptr_q];
          div_d   = div_new;
          baud_d  = div_new - 16'd1;
        end
      end
      StStart: begin
        if (baud_done) begin
          state_d = StData;
          bit_d   = 3'd0;
        end
      end
      StData: begin
        if (baud_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (baud_done) begin
          // Chain straight into the next start bit so queued bytes leave no gap.
          if (tx_en && !fifo_empty) begin
            pop     = 1'b1;
            state_d = StStart;
            shift_d = mem_q[rd_ptr_q];
            div_d   = div_new;
            baud_d  = div_new - 16'd1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_o = 1'b1;
    busy = (state_q != StIdle);
    case (state_q)
      StStart: tx_o = 1'b0;
      StData:  tx_o = shift_q[0];
      default: tx_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_user_uart_tx.sv
// Bench for user_uart_tx: directed scenarios plus random traffic, with a line
// monitor that checks every frame against the ideal 8N1 waveform.
module tb_user_uart_tx;

  logic        clk;
  logic        wb_rst_i;
  logic [15:0] clk_div;
  logic        tx_en;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        tx_o;
  logic        busy;
  logic [3:0]  fifo_count;

  int          n_checks;
  int          n_errors;
  int          cyc;
  int          push_cyc;
  logic [15:0] last_edge_div;
  logic [7:0]  model_q[$];
  int          starts[$];

  user_uart_tx #(
    .FIFO_DEPTH(8),
    .CNT_W     (4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (wb_rst_i),
    .clk_div   (clk_div),
    .tx_en     (tx_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .tx_o      (tx_o),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The divisor a frame uses is whatever clk_div held at the edge that started it.
  always @(posedge clk) begin
    cyc           <= cyc + 1;
    last_edge_div <= clk_div;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  function automatic int start_at(input int idx);
    if (idx < starts.size()) return starts[idx];
    return -1000;
  endfunction

  // Line monitor: ideal frame is d cycles per bit of {stop, data, start}, LSB first.
  initial begin : monitor
    logic [9:0] frame;
    logic [7:0] exp_b, dec;
    int         d, errs;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!wb_rst_i && tx_o == 1'b0) begin
        d = (last_edge_div == 16'd0) ? 1 : int'(last_edge_div);
        starts.push_back(cyc);
        check_eq("frame_queued", int'(model_q.size() != 0), 1);
        exp_b = 8'h00;
        if (model_q.size() != 0) exp_b = model_q.pop_front();
        frame   = {1'b1, exp_b, 1'b0};
        errs    = 0;
        dec     = 8'h00;
        aborted = 1'b0;
        for (int k = 0; k < 10 * d; k++) begin
          if (k != 0) @(negedge clk);
          if (wb_rst_i) begin
            aborted = 1'b1;
            break;
          end
          if (tx_o !== frame[k / d] || busy !== 1'b1) errs++;
          if (k / d >= 1 && k / d <= 8 && k % d == d / 2) dec[k / d - 1] = tx_o;
        end
        if (!aborted) begin
          check_eq("frame_wave", errs, 0);
          check_eq("frame_byte", int'(dec), int'(exp_b));
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_data  = b;
    n        = 0;
    acc      = 1'b0;
    do begin
      @(negedge clk);
      acc      = in_ready;
      push_cyc = cyc;
      @(posedge clk);
      n++;
    end while (!acc && n < 500);
    #1 in_valid = 1'b0;
    check_eq("push_accept", int'(acc), 1);
    if (acc) model_q.push_back(b);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (starts.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check_eq("frames_started", int'(starts.size() >= n), 1);
    step(1);
  endtask

  task automatic wait_not_busy(input int budget, output int fall_cyc);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < budget);
    fall_cyc = cyc;
    check_eq("busy_cleared", int'(busy), 0);
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || fifo_count != 4'd0) && t < budget);
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_count", int'(fifo_count), 0);
    step(2);
  endtask

  task automatic measure_busy(output int len);
    int t;
    t   = 0;
    len = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!busy && t < 100);
    while (busy && len < 2000) begin
      len++;
      @(negedge clk);
    end
    step(1);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n0, len, k, fall, gaps, p, s1, s2;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    wb_rst_i = 1'b1;
    clk_div  = 16'd4;
    tx_en    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    step(3);
    wb_rst_i = 1'b0;
    @(negedge clk);
    check_eq("rst_tx", int'(tx_o), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_ready", int'(in_ready), 1);
    check_eq("rst_count", int'(fifo_count), 0);
    step(1);

    // 1: single byte, div 4
    tx_en = 1'b1;
    n0    = starts.size();
    push(8'hA5);
    p = push_cyc;
    measure_busy(len);
    check_eq("t1_latency", start_at(n0) - p, 2);
    check_eq("t1_busy_len", len, 40);
    check_eq("t1_count", int'(fifo_count), 0);
    wait_idle(200);

    // 2: fill while disabled, then drain back to back
    tx_en   = 1'b0;
    clk_div = 16'd2;
    n0      = starts.size();
    for (int i = 0; i < 8; i++) push(8'(i));
    in_valid = 1'b1;
    in_data  = 8'h08;
    @(negedge clk);
    check_eq("t2_full_ready", int'(in_ready), 0);
    check_eq("t2_full_count", int'(fifo_count), 8);
    check_eq("t2_line_idle", int'(tx_o), 1);
    step(1);
    in_valid = 1'b0;
    tx_en    = 1'b1;
    k        = cyc;
    @(negedge clk);
    check_eq("t2_ready_during_pop", int'(in_ready), 0);
    @(negedge clk);
    check_eq("t2_ready_after_pop", int'(in_ready), 1);
    step(1);
    wait_frames(n0 + 8, 400);
    wait_idle(400);
    check_eq("t2_frames", starts.size() - n0, 8);
    check_eq("t2_first_start", start_at(n0) - k, 1);
    gaps = 0;
    for (int i = 1; i < 8; i++) if (start_at(n0 + i) - start_at(n0 + i - 1) != 20) gaps++;
    check_eq("t2_b2b_gaps", gaps, 0);
    check_eq("t2_span", start_at(n0 + 7) + 20 - start_at(n0), 160);

    // 3: div 0 behaves as div 1
    for (int i = 0; i < 2; i++) begin
      clk_div = 16'(i);
      push(8'h3C);
      measure_busy(len);
      check_eq("t3_frame_len", len, 10);
      wait_idle(100);
    end

    // 4: async reset mid-frame with bytes queued
    tx_en   = 1'b0;
    clk_div = 16'd4;
    n0      = starts.size();
    push(8'hFF);
    for (int i = 0; i < 3; i++) push(8'h11 * 8'(i + 1));
    tx_en = 1'b1;
    wait_frames(n0 + 1, 50);
    step(16);
    check_eq("t4_count_before", int'(fifo_count), 3);
    @(negedge clk);
    #1 wb_rst_i = 1'b1;
    model_q.delete();
    #1;
    check_eq("t4_rst_tx", int'(tx_o), 1);
    check_eq("t4_rst_busy", int'(busy), 0);
    check_eq("t4_rst_count", int'(fifo_count), 0);
    @(posedge clk);
    @(posedge clk);
    #1 wb_rst_i = 1'b0;
    step(60);
    check_eq("t4_no_frame", starts.size() - n0, 1);
    check_eq("t4_count_after", int'(fifo_count), 0);

    // 5: drop tx_en during the first of two frames
    tx_en   = 1'b0;
    clk_div = 16'd3;
    n0      = starts.size();
    push(8'h5A);
    push(8'hC3);
    tx_en = 1'b1;
    wait_frames(n0 + 1, 50);
    step(4);
    tx_en = 1'b0;
    wait_not_busy(100, fall);
    check_eq("t5_count", int'(fifo_count), 1);
    check_eq("t5_frames", starts.size() - n0, 1);
    step(5);
    check_eq("t5_line_idle", int'(tx_o), 1);
    tx_en = 1'b1;
    k     = cyc;
    wait_frames(n0 + 2, 50);
    check_eq("t5_restart", start_at(n0 + 1) - k, 1);
    wait_idle(200);

    // 6: clk_div change mid-frame applies to the next frame only
    tx_en   = 1'b0;
    clk_div = 16'd4;
    n0      = starts.size();
    push(8'h96);
    push(8'h69);
    tx_en = 1'b1;
    wait_frames(n0 + 1, 50);
    step(5);
    clk_div = 16'd8;
    wait_not_busy(400, fall);
    s1 = start_at(n0);
    s2 = start_at(n0 + 1);
    check_eq("t6_frame1_len", s2 - s1, 40);
    check_eq("t6_frame2_len", fall - s2, 80);
    step(2);

    // Random traffic with random divisors and gaps
    tx_en = 1'b1;
    n0    = starts.size();
    for (int i = 0; i < 24; i++) begin
      clk_div = 16'($urandom_range(0, 5));
      push(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) step($urandom_range(0, 60));
    end
    wait_idle(3000);
    check_eq("rand_frames", starts.size() - n0, 24);
    check_eq("rand_model_empty", model_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
